mips_multicycle_ctrl: RTL and testbench

Main control FSM that sequences a multicycle MIPS datapath sharing one memory port and one ALU across fetch, decode, execute, memory and write-back steps. It decodes the 6-bit opcode from the instruction register and stretches memory states while the unified memory is not ready. It also keeps a retired-instruction counter. It sits beside the datapath and replaces single-cycle combinational main control.

---
 rtl/mips_multicycle_ctrl_if.sv | 34 +++
 rtl/mips_multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main control FSM and its datapath.
//   opcode     : instruction[31:26] from IR (datapath -> control)
//   mem_ready  : unified memory completes its access this cycle (datapath -> control)
//   PCWrite .. PCSource : datapath steering strobes (control -> datapath)
// Modports: master = control FSM, slave = datapath.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS datapath (shared memory port and ALU).
// Sequences fetch/decode/execute/memory/write-back, stretches memory states
// while mem_ready is low, and counts retired instructions.
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   bus (master)   : opcode/mem_ready in, datapath control strobes out
//   state          : current FSM state (debug)
//   illegal_op     : pulses in DECODE when the opcode is unsupported
//   instr_retired  : wrapping count of completed instructions
// Handshake: the memory request (MemRead/MemWrite) is held constant while
// mem_ready is low; the access completes in the cycle mem_ready is high, and
// the FSM advances on the following edge.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]            state,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   op_legal;

    assign state = state_q;

    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything that is not sw is a load.
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;  // write-back states, branch, jump, and unused encodings
        endcase
    end

    // Last cycle of an instruction: stores only once memory accepts the write.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = bus.mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    // Control decode; everything is silenced during reset so no strobe
    // (including a write) escapes in the reset cycle.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        illegal_op      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    illegal_op  = !op_legal;
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_ADDIWB: bus.RegWrite = 1'b1;
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. A second instance with a 2-bit
// counter shares the stimulus so that counter wrap is reached quickly.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic [3:0]  state_a, state_b;
    logic        ill_a, ill_b;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl_if if_a ();
    mips_multicycle_ctrl_if if_b ();

    assign if_a.opcode    = opcode;
    assign if_a.mem_ready = mem_ready;
    assign if_b.opcode    = opcode;
    assign if_b.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(if_a.master),
        .state(state_a), .illegal_op(ill_a), .instr_retired(cnt_a)
    );

    mips_multicycle_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .bus(if_b.master),
        .state(state_b), .illegal_op(ill_b), .instr_retired(cnt_b)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    logic [15:0] ctrl;
    assign ctrl = {if_a.PCWrite, if_a.PCWriteCond, if_a.IorD, if_a.MemRead,
                   if_a.MemWrite, if_a.IRWrite, if_a.MemtoReg, if_a.RegDst,
                   if_a.RegWrite, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ALUOp,
                   if_a.PCSource};

    localparam logic [15:0] C_NONE   = 16'h0000;
    localparam logic [15:0] C_FETCH  = 16'h9410;  // mem_ready = 1
    localparam logic [15:0] C_FSTALL = 16'h1010;  // mem_ready = 0
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_MEMADR = 16'h0060;
    localparam logic [15:0] C_MEMRD  = 16'h3000;
    localparam logic [15:0] C_MEMWB  = 16'h0280;
    localparam logic [15:0] C_MEMWR  = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0048;
    localparam logic [15:0] C_ALUWB  = 16'h0180;
    localparam logic [15:0] C_BRANCH = 16'h4045;
    localparam logic [15:0] C_ADDIEX = 16'h0060;
    localparam logic [15:0] C_ADDIWB = 16'h0080;
    localparam logic [15:0] C_JUMP   = 16'h8002;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; let them settle, check this cycle, advance.
    task automatic cyc(input string tag, input logic [3:0] exp_state,
                       input logic [15:0] exp_ctrl, input logic exp_ill);
        #1;
        chk({tag, ".state"}, {28'd0, state_a}, {28'd0, exp_state});
        chk({tag, ".ctrl"},  {16'd0, ctrl},    {16'd0, exp_ctrl});
        chk({tag, ".ill"},   {31'd0, ill_a},   {31'd0, exp_ill});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        cyc("rst0", 4'd0, C_NONE, 1'b0);
        chk("rst0.cnt", cnt_a, 32'd0);
        cyc("rst1", 4'd0, C_NONE, 1'b0);
        chk("rst1.cnt", cnt_a, 32'd0);
        rst = 1'b0;

        // R-type then j
        opcode = 6'b000000;
        cyc("r.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("r.dec",   4'd1, C_DECODE, 1'b0);
        cyc("r.exec",  4'd6, C_EXEC, 1'b0);
        cyc("r.wb",    4'd7, C_ALUWB, 1'b0);
        opcode = 6'b000010;
        chk("j.cnt_mid", cnt_a, 32'd1);
        cyc("j.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("j.dec",   4'd1, C_DECODE, 1'b0);
        cyc("j.jump",  4'd11, C_JUMP, 1'b0);
        chk("rj.cnt", cnt_a, 32'd2);

        // lw with 2 fetch stalls and 3 memory-read stalls
        opcode = 6'b100011;
        mem_ready = 1'b0;
        cyc("lw.fs0", 4'd0, C_FSTALL, 1'b0);
        cyc("lw.fs1", 4'd0, C_FSTALL, 1'b0);
        mem_ready = 1'b1;
        cyc("lw.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("lw.dec",   4'd1, C_DECODE, 1'b0);
        cyc("lw.adr",   4'd2, C_MEMADR, 1'b0);
        mem_ready = 1'b0;
        cyc("lw.rs0", 4'd3, C_MEMRD, 1'b0);
        cyc("lw.rs1", 4'd3, C_MEMRD, 1'b0);
        cyc("lw.rs2", 4'd3, C_MEMRD, 1'b0);
        chk("lw.cnt_stall", cnt_a, 32'd2);
        mem_ready = 1'b1;
        cyc("lw.rd", 4'd3, C_MEMRD, 1'b0);
        cyc("lw.wb", 4'd4, C_MEMWB, 1'b0);
        chk("lw.cnt", cnt_a, 32'd3);

        // sw then beq
        opcode = 6'b101011;
        cyc("sw.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("sw.dec",   4'd1, C_DECODE, 1'b0);
        cyc("sw.adr",   4'd2, C_MEMADR, 1'b0);
        cyc("sw.wr",    4'd5, C_MEMWR, 1'b0);
        chk("sw.cnt", cnt_a, 32'd4);
        opcode = 6'b000100;
        cyc("beq.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("beq.dec",   4'd1, C_DECODE, 1'b0);
        cyc("beq.br",    4'd8, C_BRANCH, 1'b0);
        chk("beq.cnt", cnt_a, 32'd5);

        // Illegal opcode: one-cycle pulse, no retire
        opcode = 6'b111111;
        cyc("ill.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("ill.dec",   4'd1, C_DECODE, 1'b1);
        chk("ill.cnt", cnt_a, 32'd5);
        chk("ill.small_cnt", {30'd0, cnt_b}, 32'd1);

        // Three addi: small 2-bit counter goes 1 -> 2 -> 3 -> 0
        opcode = 6'b001000;
        for (int k = 0; k < 3; k++) begin
            cyc("addi.fetch", 4'd0, C_FETCH, 1'b0);
            cyc("addi.dec",   4'd1, C_DECODE, 1'b0);
            cyc("addi.ex",    4'd9, C_ADDIEX, 1'b0);
            if (k == 2) chk("wrap.small_pre", {30'd0, cnt_b}, 32'd3);
            cyc("addi.wb",    4'd10, C_ADDIWB, 1'b0);
        end
        chk("wrap.small", {30'd0, cnt_b}, 32'd0);
        chk("addi.cnt", cnt_a, 32'd8);

        // Reset during a MEMWR stall
        opcode = 6'b101011;
        cyc("swr.fetch", 4'd0, C_FETCH, 1'b0);
        cyc("swr.dec",   4'd1, C_DECODE, 1'b0);
        cyc("swr.adr",   4'd2, C_MEMADR, 1'b0);
        mem_ready = 1'b0;
        cyc("swr.stall", 4'd5, C_MEMWR, 1'b0);
        chk("swr.cnt_stall", cnt_a, 32'd8);
        rst = 1'b1;
        cyc("swr.rst", 4'd5, C_NONE, 1'b0);
        cyc("swr.post", 4'd0, C_NONE, 1'b0);
        chk("swr.cnt", cnt_a, 32'd0);
        chk("swr.small_cnt", {30'd0, cnt_b}, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc("rel.fetch", 4'd0, C_FETCH, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
